cskip_seq_adder_ctrl: RTL and testbench

//   Multi-cycle sequencer that computes a WIDTH-bit add by reusing one SLICE-bit carry-skip

---
 rtl/cskip_pkg.sv | 23 ++
 rtl/cskip_slice.sv | 37 +++
 rtl/cskip_seq_adder_ctrl.sv | 121 ++++++++++++
 tb/tb_cskip_seq_adder_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cskip_pkg.sv
// Shared types and sizing helpers for the sequential carry-skip adder family.
package cskip_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned SKIP_GRP = 4;

    function automatic int unsigned calc_nslice(input int unsigned width, input int unsigned slice);
        return width / slice;
    endfunction

    // Slice index is never narrower than one bit, even for a single-slice configuration.
    function automatic int unsigned calc_idx_w(input int unsigned width, input int unsigned slice);
        int unsigned n;
        n = width / slice;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cskip_slice.sv
// Combinational SLICE-bit carry-skip adder: 4-bit ripple groups, each bypassed by a skip mux
// when every bit in the group propagates.
module cskip_slice
    import cskip_pkg::*;
#(
    parameter int unsigned SLICE = 8
) (
    output logic [SLICE-1:0] sum,
    output logic             cout,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin
);

    localparam int unsigned NGRP = SLICE / SKIP_GRP;

    logic [SLICE-1:0] p;
    logic [SLICE-1:0] g;
    logic [NGRP:0]    gc;

    assign p     = a ^ b;
    assign g     = a & b;
    assign gc[0] = cin;

    for (genvar grp = 0; grp < NGRP; grp++) begin : g_grp
        logic [SKIP_GRP:0] rc;
        assign rc[0] = gc[grp];
        for (genvar j = 0; j < SKIP_GRP; j++) begin : g_bit
            assign sum[grp*SKIP_GRP+j] = p[grp*SKIP_GRP+j] ^ rc[j];
            assign rc[j+1]             = g[grp*SKIP_GRP+j] | (p[grp*SKIP_GRP+j] & rc[j]);
        end
        assign gc[grp+1] = (&p[grp*SKIP_GRP +: SKIP_GRP]) ? gc[grp] : rc[SKIP_GRP];
    end

    assign cout = gc[NGRP];

endmodule

// File: rtl/cskip_seq_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder that reuses one SLICE-bit carry-skip slice, LSB slice first,
// with a start/ready handshake and a one-cycle done pulse.
module cskip_seq_adder_ctrl
    import cskip_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NSLICE = calc_nslice(WIDTH, SLICE);
    localparam int unsigned IDX_W  = calc_idx_w(WIDTH, SLICE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [SLICE-1:0] slice_a, slice_b, slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] merged;

    assign slice_a = a_q[idx_q*SLICE +: SLICE];
    assign slice_b = b_q[idx_q*SLICE +: SLICE];

    cskip_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .sum  (slice_sum),
        .cout (slice_cout),
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        shadow_d = shadow_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        merged                          = shadow_q;
        merged[idx_q*SLICE +: SLICE]    = slice_sum;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                shadow_d = merged;
                carry_d  = slice_cout;
                idx_d    = idx_q + IDX_W'(1);
                // Result is published only once, with the last slice merged in.
                if (idx_q == IDX_LAST) begin
                    sum_d   = merged;
                    cout_d  = slice_cout;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shadow_q <= shadow_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign ready = (state_q == StIdle);
    assign done  = (state_q == StDone);
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_cskip_seq_adder_ctrl.sv
// Directed bench for cskip_seq_adder_ctrl with hand-computed expected results.
module tb_cskip_seq_adder_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        ready;
    logic        done;
    logic [31:0] sum;
    logic        cout;

    int checks;
    int errors;
    int cyc;

    cskip_seq_adder_ctrl #(
        .WIDTH (32),
        .SLICE (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accepts one add, waits (bounded) for done, checks latency and result.
    task automatic run_add(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic cv, input logic [32:0] exp, output int done_cyc);
        int n;
        n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 64'(ready), 64'd1);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = '1;
        b     = '1;
        cin   = 1'b1;
        n     = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        done_cyc = cyc;
        chk({tag, "_latency"}, 64'(n), 64'd4);
        chk({tag, "_result"}, 64'({cout, sum}), 64'(exp));
        tick();
        chk({tag, "_done_drop"}, 64'(done), 64'd0);
        chk({tag, "_ready_back"}, 64'(ready), 64'd1);
    endtask

    initial begin
        int d1, d2, ndone, overlap, first_d, second_d;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        tick();
        tick();
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'({cout, sum}), 64'd0);
        rst_n = 1'b1;
        tick();

        run_add("t1", 32'hA0A0FFFF, 32'hA0BFFFE0, 1'b0, {1'b1, 32'h4160FFDF}, d1);
        run_add("t2", 32'hFFFFFFFF, 32'h00000000, 1'b1, {1'b1, 32'h00000000}, d1);

        // Back-to-back: second start issued in the first ready cycle after done.
        run_add("t3a", 32'h11111111, 32'h22222222, 1'b0, {1'b0, 32'h33333333}, d1);
        run_add("t3b", 32'h00000000, 32'h00000000, 1'b0, {1'b0, 32'h00000000}, d2);
        chk("t3_spacing", 64'(d2 - d1), 64'd6);

        // Start pulsed mid-run must be ignored.
        a     = 32'hDFFFE8CA;
        b     = 32'hCFFFF8CA;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a     = '0;
        b     = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                ndone++;
                chk("t4_result", 64'({cout, sum}), {31'd0, 1'b1, 32'hAFFFE194});
            end
            tick();
        end
        chk("t4_ndone", 64'(ndone), 64'd1);
        chk("t4_ready", 64'(ready), 64'd1);

        // Reset on the second RUN edge aborts the add.
        a     = 32'hFFFFFFFF;
        b     = 32'h00000001;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_ready", 64'(ready), 64'd1);
        chk("t5_result", 64'({cout, sum}), 64'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("t5_ndone", 64'(ndone), 64'd0);
        run_add("t5b", 32'h12345678, 32'h11111111, 1'b0, {1'b0, 32'h23456789}, d1);

        // start held high: one accept per six cycles, ready and done never coincide.
        a        = 32'h00000001;
        b        = 32'h00000002;
        cin      = 1'b0;
        start    = 1'b1;
        ndone    = 0;
        overlap  = 0;
        first_d  = 0;
        second_d = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ready && done) overlap++;
            if (done) begin
                ndone++;
                if (ndone == 1) first_d = cyc;
                if (ndone == 2) second_d = cyc;
            end
        end
        start = 1'b0;
        chk("t6_overlap", 64'(overlap), 64'd0);
        chk("t6_ndone", 64'(ndone), 64'd5);
        chk("t6_spacing", 64'(second_d - first_d), 64'd6);
        chk("t6_result", 64'({cout, sum}), 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
